// File: rtl/spi_mem_dpram_if.sv
// Avalon-MM memory port bundle: one instance per port of spi_mem_dpram.
// The master modport drives requests; the slave modport returns read data and stall.
interface spi_mem_dpram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/spi_mem_dpram.sv
// True dual-port Avalon-MM RAM with post-reset clear, byte lanes and write-collision arbitration.
// Define SPI_MEM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module spi_mem_dpram #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int CLEAR_ON_RESET = 1,
  parameter     INIT_FILE      = "NiosFirmware_spi_mem.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  spi_mem_dpram_if.slave      a,
  spi_mem_dpram_if.slave      b,
  output logic                init_done,
  output logic                collision,
  output logic [15:0]         collision_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              busy;
  logic              clear_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port signals gathered into arrays so both ports share one description.
  logic [ADDR_W-1:0] addr   [2];
  logic [NB-1:0]     be     [2];
  logic [DATA_W-1:0] wdata  [2];
  logic [DATA_W-1:0] rdata  [2];
  logic              rvalid [2];
  logic [1:0]        wr_acc;
  logic [1:0]        rd_acc;
  logic              same_addr;
  logic              collide;
  logic [NB-1:0]     b_lane;

  assign addr[0]  = a.address;
  assign addr[1]  = b.address;
  assign be[0]    = a.byteenable;
  assign be[1]    = b.byteenable;
  assign wdata[0] = a.writedata;
  assign wdata[1] = b.writedata;

  assign busy      = (state_reg != ST_RUN);
  assign init_done = (state_reg == ST_RUN);
  assign clear_we  = (state_reg == ST_CLEAR) && (CLEAR_ON_RESET != 0);

  assign a.waitrequest   = busy;
  assign b.waitrequest   = busy;
  assign a.readdata      = rdata[0];
  assign b.readdata      = rdata[1];
  assign a.readdatavalid = rvalid[0];
  assign b.readdatavalid = rvalid[1];

  // read+write on one port counts as a write only
  always_comb begin
    wr_acc    = '0;
    rd_acc    = '0;
    wr_acc[0] = a.chipselect & a.write & ~busy;
    wr_acc[1] = b.chipselect & b.write & ~busy;
    rd_acc[0] = a.chipselect & a.read & ~a.write & ~busy;
    rd_acc[1] = b.chipselect & b.read & ~b.write & ~busy;
  end

  assign same_addr = (addr[0] == addr[1]);
  assign collide   = wr_acc[0] & wr_acc[1] & same_addr;
  // On a same-address dual write, port A owns every lane it enables.
  assign b_lane    = be[1] & ~((wr_acc[0] && same_addr) ? be[0] : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
    end else if (state_reg == ST_CLEAR) begin
      if (CLEAR_ON_RESET == 0 || ptr_reg == '1)
        state_reg <= ST_RUN;
      ptr_reg <= ptr_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[ptr_reg] <= '0;
    end else begin
      for (int l = 0; l < NB; l++) begin
        if (wr_acc[0] && be[0][l])
          mem[addr[0]][l*8 +: 8] <= wdata[0][l*8 +: 8];
        if (wr_acc[1] && b_lane[l])
          mem[addr[1]][l*8 +: 8] <= wdata[1][l*8 +: 8];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] s1_data_reg;
      logic              s1_valid_reg;

      // Registered read samples the array before this edge's writes land: old data on RDW.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_data_reg  <= '0;
          s1_valid_reg <= 1'b0;
        end else begin
          s1_valid_reg <= rd_acc[gi];
          if (rd_acc[gi])
            s1_data_reg <= mem[addr[gi]];
        end
      end

`ifdef SPI_MEM_OUTREG_EN
      logic [DATA_W-1:0] s2_data_reg;
      logic              s2_valid_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s2_data_reg  <= '0;
          s2_valid_reg <= 1'b0;
        end else begin
          s2_valid_reg <= s1_valid_reg;
          if (s1_valid_reg)
            s2_data_reg <= s1_data_reg;
        end
      end

      assign rdata[gi]  = s2_data_reg;
      assign rvalid[gi] = s2_valid_reg;
`else
      assign rdata[gi]  = s1_data_reg;
      assign rvalid[gi] = s1_valid_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= collide;
      if (collide && collision_cnt != 16'hFFFF)
        collision_cnt <= collision_cnt + 16'd1;
    end
  end

endmodule
